// File: rtl/serv_lsu_if_if.sv
// Bundle of LSU signals: command/serial data toward the core, Wishbone toward memory.
// The master modport is the core/bus side; the slave modport is the LSU itself.
interface serv_lsu_if_if #(
  parameter int W = 1
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         we;
  logic         is_signed;
  logic         word;
  logic         half;
  logic [31:0]  adr;
  logic [W-1:0] wdat;
  logic         wdat_valid;
  logic [W-1:0] rdat;
  logic         rdat_valid;
  logic         misalign;
  logic         err;
  logic         done;
  logic [31:0]  wb_adr;
  logic [31:0]  wb_dat;
  logic [3:0]   wb_sel;
  logic         wb_we;
  logic         wb_cyc;
  logic [31:0]  wb_rdt;
  logic         wb_ack;

  modport master (
    output cmd_valid, we, is_signed, word, half, adr, wdat, wdat_valid, wb_rdt, wb_ack,
    input  cmd_ready, rdat, rdat_valid, misalign, err, done,
           wb_adr, wb_dat, wb_sel, wb_we, wb_cyc
  );

  modport slave (
    input  cmd_valid, we, is_signed, word, half, adr, wdat, wdat_valid, wb_rdt, wb_ack,
    output cmd_ready, rdat, rdat_valid, misalign, err, done,
           wb_adr, wb_dat, wb_sel, wb_we, wb_cyc
  );
endinterface

// File: rtl/serv_lsu_if.sv
// Serial load/store unit bridging a W-bit datapath to Wishbone; SERV_LSU_TIMEOUT_EN adds a bus timeout.
// Loads: cyc the cycle after accept, first beat the cycle after ack; the bus wait is unbounded unless the timeout is enabled.
module serv_lsu_if #(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  serv_lsu_if_if.slave  bus
);
  localparam int         BEATS = 32 / W;
  localparam logic [4:0] LAST  = 5'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, BUS, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        we_q, sgn_q, word_q, half_q;
  logic [1:0]  lsb_q;
  logic [31:0] wb_adr_q;
  logic [31:0] buf_q;
  logic [4:0]  cnt_q;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        accept;
  logic        misaligned;
  logic        expire;
  logic [31:0] rdt_sh;
  logic [31:0] load_ext;
  logic [3:0]  sel;

  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign misaligned = WITH_CSR && ((bus.adr[0] && (bus.word || bus.half)) ||
                                   (bus.adr[1] && bus.word));

`ifdef SERV_LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // Held at zero outside BUS, so every bus cycle starts counting from 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)           tmo_q <= '0;
    else if (state_q != BUS) tmo_q <= '0;
    else if (!bus.wb_ack)   tmo_q <= tmo_q + TW'(1);
  end

  assign expire = (state_q == BUS) && (tmo_q == TW'(TIMEOUT - 1));
`else
  localparam int tmo_limit_unused = TIMEOUT;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            mis_d  = 1'b1;
            done_d = 1'b1;
          end else if (bus.we) begin
            state_d = FILL;
          end else begin
            state_d = BUS;
          end
        end
      end
      FILL: begin
        if (bus.wdat_valid && cnt_q == LAST) state_d = BUS;
      end
      BUS: begin
        // An ack in the expiry cycle still completes normally.
        if (bus.wb_ack) begin
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdt_sh = bus.wb_rdt >> {lsb_q, 3'b000};

  // Extension is applied at capture so DRAIN only has to shift.
  always_comb begin
    load_ext = rdt_sh;
    if (!word_q) begin
      if (half_q) load_ext = {{16{sgn_q & rdt_sh[15]}}, rdt_sh[15:0]};
      else        load_ext = {{24{sgn_q & rdt_sh[7]}},  rdt_sh[7:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      word_q   <= 1'b0;
      half_q   <= 1'b0;
      lsb_q    <= 2'b00;
      wb_adr_q <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= bus.we;
        sgn_q    <= bus.is_signed;
        word_q   <= bus.word;
        half_q   <= bus.half;
        lsb_q    <= bus.adr[1:0];
        wb_adr_q <= {bus.adr[31:2], 2'b00};
        cnt_q    <= '0;
      end
      unique case (state_q)
        FILL: begin
          if (bus.wdat_valid) begin
            buf_q <= {bus.wdat, buf_q[31:W]};
            cnt_q <= cnt_q + 5'd1;
          end
        end
        BUS: begin
          if (bus.wb_ack && !we_q) begin
            buf_q <= load_ext;
            cnt_q <= '0;
          end
        end
        DRAIN: begin
          buf_q <= buf_q >> W;
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel = 4'b0000;
    if (state_q == BUS) begin
      if (word_q)      sel = 4'b1111;
      else if (half_q) sel = 4'b0011 << lsb_q;
      else             sel = 4'b0001 << lsb_q;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.wb_cyc     = (state_q == BUS);
  assign bus.wb_we      = (state_q == BUS) & we_q;
  assign bus.wb_sel     = sel;
  assign bus.wb_adr     = wb_adr_q;
  assign bus.wb_dat     = buf_q << {lsb_q, 3'b000};
  assign bus.rdat_valid = (state_q == DRAIN);
  assign bus.rdat       = (state_q == DRAIN) ? buf_q[W-1:0] : '0;
  assign bus.done       = done_q;
  assign bus.misalign   = mis_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_serv_lsu_if.sv
// Directed bench for serv_lsu_if: one W=1 and one W=4 instance sharing clock and reset.
module tb_serv_lsu_if;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] res;
  logic [31:0] sdat;

  always #5 clk = ~clk;

  serv_lsu_if_if #(.W(1)) b1 ();
  serv_lsu_if_if #(.W(4)) b4 ();

  serv_lsu_if #(.W(1), .WITH_CSR(1), .TIMEOUT(4)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  serv_lsu_if #(.W(4), .WITH_CSR(1), .TIMEOUT(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.cmd_valid = 0; b1.we = 0; b1.is_signed = 0; b1.word = 0; b1.half = 0; b1.adr = 0;
    b1.wdat = 0; b1.wdat_valid = 0; b1.wb_rdt = 0; b1.wb_ack = 0;
    b4.cmd_valid = 0; b4.we = 0; b4.is_signed = 0; b4.word = 0; b4.half = 0; b4.adr = 0;
    b4.wdat = 0; b4.wdat_valid = 0; b4.wb_rdt = 0; b4.wb_ack = 0;
    tick(); tick();

    // Reset state
    chk("rst_ready", b1.cmd_ready, 1);
    chk("rst_cyc", b1.wb_cyc, 0);
    chk("rst_sel", b1.wb_sel, 0);
    chk("rst_adr", b1.wb_adr, 0);
    chk("rst_dat", b4.wb_dat, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_rvld", b4.rdat_valid, 0);
    chk("rst_rdat", b4.rdat, 0);
    rst_n = 1;
    tick();

    // W=1 signed byte load at 0x1003
    b1.cmd_valid = 1; b1.we = 0; b1.is_signed = 1; b1.word = 0; b1.half = 0; b1.adr = 32'h1003;
    tick();
    b1.cmd_valid = 0;
    chk("sb_cyc", b1.wb_cyc, 1);
    chk("sb_sel", b1.wb_sel, 4'b1000);
    chk("sb_we", b1.wb_we, 0);
    chk("sb_adr", b1.wb_adr, 32'h1000);
    chk("sb_ready", b1.cmd_ready, 0);
    b1.wb_rdt = 32'h80FF_FFFF; b1.wb_ack = 1;
    tick();
    b1.wb_ack = 0;
    chk("sb_cyc_fall", b1.wb_cyc, 0);
    res = 0;
    for (int i = 0; i < 32; i++) begin
      chk("sb_rvld", b1.rdat_valid, 1);
      res[i] = b1.rdat[0];
      tick();
    end
    chk("sb_result", res, 32'hFFFF_FF80);
    chk("sb_rvld_end", b1.rdat_valid, 0);
    chk("sb_rdat_idle", b1.rdat, 0);
    chk("sb_done", b1.done, 1);
    chk("sb_ready_end", b1.cmd_ready, 1);
    tick();
    chk("sb_done_pulse", b1.done, 0);

    // W=4 word store at 0x2000, one idle gap in the serial data
    sdat = 32'hDEAD_BEEF;
    b4.cmd_valid = 1; b4.we = 1; b4.word = 1; b4.half = 0; b4.is_signed = 0; b4.adr = 32'h2000;
    tick();
    b4.cmd_valid = 0;
    chk("sw_ready", b4.cmd_ready, 0);
    chk("sw_cyc_fill", b4.wb_cyc, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        b4.wdat_valid = 0;
        tick();
      end
      b4.wdat = sdat[4*i +: 4]; b4.wdat_valid = 1;
      tick();
    end
    b4.wdat_valid = 0;
    chk("sw_cyc", b4.wb_cyc, 1);
    chk("sw_dat", b4.wb_dat, 32'hDEAD_BEEF);
    chk("sw_sel", b4.wb_sel, 4'b1111);
    chk("sw_we", b4.wb_we, 1);
    chk("sw_adr", b4.wb_adr, 32'h2000);
    b4.wb_ack = 1;
    tick();
    b4.wb_ack = 0;
    chk("sw_cyc_fall", b4.wb_cyc, 0);
    chk("sw_done", b4.done, 1);
    chk("sw_rvld", b4.rdat_valid, 0);
    tick();
    chk("sw_done_pulse", b4.done, 0);

    // Misaligned half load at 0x3001
    b1.cmd_valid = 1; b1.we = 0; b1.half = 1; b1.word = 0; b1.is_signed = 0; b1.adr = 32'h3001;
    tick();
    b1.cmd_valid = 0;
    chk("mis_flag", b1.misalign, 1);
    chk("mis_done", b1.done, 1);
    chk("mis_cyc", b1.wb_cyc, 0);
    chk("mis_ready", b1.cmd_ready, 1);
    tick();
    chk("mis_flag_pulse", b1.misalign, 0);
    chk("mis_cyc2", b1.wb_cyc, 0);
    chk("mis_rvld", b1.rdat_valid, 0);

    // Unsigned half load at 0x4002 with 5 wait cycles
    b1.cmd_valid = 1; b1.half = 1; b1.adr = 32'h4002; b1.wb_rdt = 32'h8001_0000;
    tick();
    b1.cmd_valid = 0;
    for (int i = 0; i < 6; i++) begin
      chk("uh_cyc", b1.wb_cyc, 1);
      chk("uh_sel", b1.wb_sel, 4'b1100);
      chk("uh_adr", b1.wb_adr, 32'h4000);
      if (i == 5) b1.wb_ack = 1;
      tick();
    end
    b1.wb_ack = 0;
    chk("uh_cyc_fall", b1.wb_cyc, 0);
    res = 0;
    for (int i = 0; i < 32; i++) begin
      res[i] = b1.rdat[0];
      tick();
    end
    chk("uh_result", res, 32'h0000_8001);
    chk("uh_done", b1.done, 1);

    // W=4 word load at 0x6000 without ack
    b4.cmd_valid = 1; b4.we = 0; b4.word = 1; b4.adr = 32'h6000; b4.wb_rdt = 32'h1234_5678;
    tick();
    b4.cmd_valid = 0;
`ifdef SERV_LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_cyc", b4.wb_cyc, 1);
      tick();
    end
    chk("to_cyc_fall", b4.wb_cyc, 0);
    chk("to_err", b4.err, 1);
    chk("to_done", b4.done, 1);
    chk("to_rvld", b4.rdat_valid, 0);
    tick();
    chk("to_err_pulse", b4.err, 0);
    chk("to_rvld2", b4.rdat_valid, 0);
`else
    for (int i = 0; i < 10; i++) begin
      chk("wt_cyc", b4.wb_cyc, 1);
      chk("wt_err", b4.err, 0);
      tick();
    end
    b4.wb_ack = 1;
    tick();
    b4.wb_ack = 0;
    res = 0;
    for (int i = 0; i < 8; i++) begin
      chk("wl_rvld", b4.rdat_valid, 1);
      res[4*i +: 4] = b4.rdat;
      tick();
    end
    chk("wl_result", res, 32'h1234_5678);
    chk("wl_done", b4.done, 1);
`endif

    // Reset during DRAIN beat 3
    b1.cmd_valid = 1; b1.half = 0; b1.word = 0; b1.adr = 32'h5000; b1.wb_rdt = 32'h0000_00A5;
    tick();
    b1.cmd_valid = 0; b1.wb_ack = 1;
    tick();
    b1.wb_ack = 0;
    tick(); tick(); tick();
    chk("rd_beat3", b1.rdat_valid, 1);
    rst_n = 0;
    tick();
    chk("rd_rvld", b1.rdat_valid, 0);
    chk("rd_done", b1.done, 0);
    chk("rd_cyc", b1.wb_cyc, 0);
    rst_n = 1;
    tick();
    chk("rd_rvld2", b1.rdat_valid, 0);
    chk("rd_done2", b1.done, 0);
    chk("rd_ready", b1.cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
